// File: rtl/tcp_pkt_gen_mc.sv
// Multi-channel packet generator: replays template beats per channel,
// round-robin arbitrated onto one tx stream with valid/ready backpressure.
module tcp_pkt_gen_mc #(
   parameter int DAT_WID = 256,
   parameter int MSG_WID = 20,
   parameter int NCH     = 4,
   parameter int AWID    = 10,
   parameter int LEN_WID = 16,
   parameter int CNT_WID = 32,
   localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tpl_wen,
   input  logic [AWID-1:0]            tpl_waddr,
   input  logic [MSG_WID+DAT_WID-1:0] tpl_wdata,
   input  logic [NCH-1:0]             cfg_en,
   input  logic [NCH*AWID-1:0]        cfg_base,
   input  logic [NCH*LEN_WID-1:0]     cfg_len,
   input  logic [NCH*CNT_WID-1:0]     cfg_num,
   input  logic [NCH*CNT_WID-1:0]     cfg_gap,
   output logic                       tx_pkt_vld,
   input  logic                       tx_pkt_rdy,
   output logic [DAT_WID-1:0]         tx_pkt_dat,
   output logic [MSG_WID-1:0]         tx_pkt_msg,
   output logic                       tx_pkt_sop,
   output logic                       tx_pkt_eop,
   output logic [CHW-1:0]             tx_pkt_chn,
   output logic [CNT_WID-1:0]         tx_pkt_seq,
   output logic [NCH-1:0]             sts_done,
   output logic                       sts_busy
);

   localparam int TW = MSG_WID + DAT_WID;
   localparam int EW = TW + 2;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   logic [TW-1:0]      tpl_mem [2**AWID];
   logic               tpl_ren;
   logic [AWID-1:0]    tpl_raddr;
   logic [TW-1:0]      rd_word_q;

   state_t             state_q, state_d;
   logic [CHW-1:0]     ptr_q, ptr_d;
   logic [CHW-1:0]     cur_chn_q, cur_chn_d;
   logic [AWID-1:0]    cur_base_q, cur_base_d;
   logic [LEN_WID-1:0] cur_len_q, cur_len_d;
   logic [CNT_WID-1:0] cur_seq_q, cur_seq_d;
   logic [LEN_WID-1:0] beat_q, beat_d;
   logic               rd_vld_q, rd_vld_d;
   logic               rd_sop_q, rd_sop_d;
   logic               rd_eop_q, rd_eop_d;

   logic [EW-1:0]      ent_q [2];
   logic [EW-1:0]      ent_d [2];
   logic               wptr_q, wptr_d;
   logic               rptr_q, rptr_d;
   logic [1:0]         cnt_q, cnt_d;

   logic [CNT_WID-1:0] gcnt_q [NCH];
   logic [CNT_WID-1:0] gcnt_d [NCH];
   logic [CNT_WID-1:0] scnt_q [NCH];
   logic [CNT_WID-1:0] scnt_d [NCH];
   logic [NCH-1:0]     pend_q, pend_d;

   logic [AWID-1:0]    base_c [NCH];
   logic [LEN_WID-1:0] len_c  [NCH];
   logic [CNT_WID-1:0] num_c  [NCH];
   logic [CNT_WID-1:0] thr_c  [NCH];
   logic [NCH-1:0]     done_c, elig_c, fly_c, fin_c;

   logic               gnt_vld, grant, push, pop, room, out_eop;
   logic [CHW-1:0]     gnt_chn;

   assign push    = rd_vld_q;
   assign pop     = (cnt_q != 2'd0) && tx_pkt_rdy;
   assign out_eop = ent_q[rptr_q][0];
   assign room    = (cnt_q == 2'd0)
                 || (cnt_q == 2'd1 && (!rd_vld_q || pop))
                 || (cnt_q == 2'd2 && pop && !rd_vld_q);

   // template RAM: registered read, old data on same-address collision
   always_ff @(posedge clk) begin
      if (tpl_wen) tpl_mem[tpl_waddr] <= tpl_wdata;
      if (tpl_ren) rd_word_q <= tpl_mem[tpl_raddr];
   end

   // per-channel config slices and eligibility
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         base_c[c] = cfg_base[c*AWID +: AWID];
         len_c[c]  = cfg_len[c*LEN_WID +: LEN_WID];
         num_c[c]  = cfg_num[c*CNT_WID +: CNT_WID];
         thr_c[c]  = (cfg_gap[c*CNT_WID +: CNT_WID] == '0) ? '0
                   : cfg_gap[c*CNT_WID +: CNT_WID] - 1'b1;
         done_c[c] = cfg_en[c] && (num_c[c] != '0)
                   && (scnt_q[c] == num_c[c]);
         elig_c[c] = pend_q[c] && cfg_en[c] && (len_c[c] != '0);
      end
   end

   // round-robin pick: first eligible channel at or after the pointer
   always_comb begin
      gnt_vld = 1'b0;
      gnt_chn = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (elig_c[(int'(ptr_q) + i) % NCH]) begin
            gnt_vld = 1'b1;
            gnt_chn = CHW'((int'(ptr_q) + i) % NCH);
         end
      end
   end

   // arbiter FSM, read issue and buffer-credit tracking
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cur_chn_d  = cur_chn_q;
      cur_base_d = cur_base_q;
      cur_len_d  = cur_len_q;
      cur_seq_d  = cur_seq_q;
      beat_d     = beat_q;
      tpl_ren    = 1'b0;
      tpl_raddr  = '0;
      rd_sop_d   = 1'b0;
      rd_eop_d   = 1'b0;
      grant      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               grant      = 1'b1;
               state_d    = S_SEND;
               ptr_d      = (gnt_chn == CHW'(NCH - 1)) ? '0
                          : gnt_chn + 1'b1;
               cur_chn_d  = gnt_chn;
               cur_base_d = base_c[gnt_chn];
               cur_len_d  = len_c[gnt_chn];
               cur_seq_d  = scnt_q[gnt_chn];
               beat_d     = LEN_WID'(1);
               tpl_ren    = 1'b1;
               tpl_raddr  = base_c[gnt_chn];
               rd_sop_d   = 1'b1;
               rd_eop_d   = (len_c[gnt_chn] == LEN_WID'(1));
            end
         end
         S_SEND: begin
            if (beat_q < cur_len_q && room) begin
               tpl_ren   = 1'b1;
               tpl_raddr = cur_base_q + AWID'(beat_q);
               rd_sop_d  = (beat_q == '0);
               rd_eop_d  = (beat_q == cur_len_q - 1'b1);
               beat_d    = beat_q + 1'b1;
            end
            if (pop && out_eop) state_d = S_IDLE;
         end
         default: ;
      endcase
      rd_vld_d = tpl_ren;
   end

   // 2-entry skid FIFO between RAM read data and tx port
   always_comb begin
      ent_d[0] = ent_q[0];
      ent_d[1] = ent_q[1];
      if (push) ent_d[wptr_q] = {rd_word_q, rd_sop_q, rd_eop_q};
      wptr_d = push ? ~wptr_q : wptr_q;
      rptr_d = pop ? ~rptr_q : rptr_q;
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   // per-channel gap, sent and pending tracking
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         gcnt_d[c] = gcnt_q[c];
         scnt_d[c] = scnt_q[c];
         pend_d[c] = pend_q[c];
         fly_c[c]  = (state_q == S_SEND) && (cur_chn_q == CHW'(c));
         fin_c[c]  = fly_c[c] && pop && out_eop;
         if (!cfg_en[c]) begin
            gcnt_d[c] = '0;
            scnt_d[c] = '0;
            pend_d[c] = 1'b0;
         end else if (fin_c[c]) begin
            scnt_d[c] = scnt_q[c] + 1'b1;
            gcnt_d[c] = '0;
         end else if (grant && gnt_chn == CHW'(c)) begin
            pend_d[c] = 1'b0;
         end else if (len_c[c] != '0 && !done_c[c]
                      && !pend_q[c] && !fly_c[c]) begin
            if (gcnt_q[c] >= thr_c[c]) pend_d[c] = 1'b1;
            else gcnt_d[c] = gcnt_q[c] + 1'b1;
         end
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         cur_chn_q  <= '0;
         cur_base_q <= '0;
         cur_len_q  <= '0;
         cur_seq_q  <= '0;
         beat_q     <= '0;
         rd_vld_q   <= 1'b0;
         rd_sop_q   <= 1'b0;
         rd_eop_q   <= 1'b0;
         ent_q[0]   <= '0;
         ent_q[1]   <= '0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         cnt_q      <= 2'd0;
         pend_q     <= '0;
         for (int c = 0; c < NCH; c++) begin
            gcnt_q[c] <= '0;
            scnt_q[c] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cur_chn_q  <= cur_chn_d;
         cur_base_q <= cur_base_d;
         cur_len_q  <= cur_len_d;
         cur_seq_q  <= cur_seq_d;
         beat_q     <= beat_d;
         rd_vld_q   <= rd_vld_d;
         rd_sop_q   <= rd_sop_d;
         rd_eop_q   <= rd_eop_d;
         ent_q[0]   <= ent_d[0];
         ent_q[1]   <= ent_d[1];
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         for (int c = 0; c < NCH; c++) begin
            gcnt_q[c] <= gcnt_d[c];
            scnt_q[c] <= scnt_d[c];
         end
      end
   end

   assign tx_pkt_vld = (cnt_q != 2'd0);
   assign {tx_pkt_msg, tx_pkt_dat, tx_pkt_sop, tx_pkt_eop} = ent_q[rptr_q];
   assign tx_pkt_chn = cur_chn_q;
   assign tx_pkt_seq = cur_seq_q;
   assign sts_done   = done_c;
   assign sts_busy   = (state_q == S_SEND) || grant;

endmodule
